// File: rtl/codec_init_seq.sv
// rtl/codec_init_seq.sv - table-driven CODEC probe and register initialisation sequencer
module codec_init_seq #(
  parameter int                                    ADDR_W         = 4,
  parameter int                                    DATA_W         = 8,
  parameter int                                    NUM_REGS       = 6,
  parameter logic [NUM_REGS*(ADDR_W+DATA_W)-1:0]   INIT_TABLE     = '0,
  parameter logic [ADDR_W-1:0]                     PROBE_ADDR     = '0,
  parameter bit                                    VERIFY         = 1'b1,
  parameter int                                    TIMEOUT_CYCLES = 4096,
  parameter int                                    MAX_RETRIES    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  output logic              codec_rd_en,
  output logic              codec_wr_en,
  output logic [ADDR_W-1:0] codec_reg_addr,
  output logic [DATA_W-1:0] codec_data_out,
  input  logic [DATA_W-1:0] codec_data_in,
  input  logic              codec_data_in_valid,
  input  logic              controller_busy,
  output logic              codec_is_alive,
  output logic              init_done,
  output logic              init_error,
  output logic [7:0]        cur_index
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);
  localparam int RTY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [3:0] {
    PROBE_ISSUE, PROBE_WAIT, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, NEXT, DONE, ERROR
  } state_t;

  state_t              r_state;
  logic                r_rd_en;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_alive;
  logic                r_done;
  logic                r_error;
  logic [7:0]          r_index;
  logic [RTY_W-1:0]    r_retry;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_seen_busy;

  logic [ENTRY_W-1:0]  w_entry;
  logic [ADDR_W-1:0]   w_tbl_addr;
  logic [DATA_W-1:0]   w_tbl_data;
  logic                w_tmo_hit;
  logic                w_can_retry;
  logic                w_last;
  logic                w_in_wait;
  logic                w_resp;
  logic                w_mismatch;
  logic                w_fail;
  state_t              w_retry_st;

  assign w_entry     = INIT_TABLE[int'(r_index)*ENTRY_W +: ENTRY_W];
  assign w_tbl_addr  = w_entry[ENTRY_W-1:DATA_W];
  assign w_tbl_data  = w_entry[DATA_W-1:0];
  assign w_tmo_hit   = (int'(r_tmo) == TIMEOUT_CYCLES - 1);
  assign w_can_retry = (int'(r_retry) < MAX_RETRIES);
  assign w_last      = (int'(r_index) == NUM_REGS - 1);

  // Classify the current wait cycle: response seen, verify mismatch, failure and where a retry restarts
  always_comb begin
    w_in_wait  = 1'b0;
    w_resp     = 1'b0;
    w_mismatch = 1'b0;
    w_retry_st = r_state;
    case (r_state)
      PROBE_WAIT: begin
        w_in_wait  = 1'b1;
        w_resp     = codec_data_in_valid;
        w_retry_st = PROBE_ISSUE;
      end
      WR_WAIT: begin
        w_in_wait  = 1'b1;
        w_resp     = r_seen_busy && !controller_busy;
        w_retry_st = WR_ISSUE;
      end
      RD_WAIT: begin
        w_in_wait  = 1'b1;
        w_resp     = codec_data_in_valid;
        w_mismatch = codec_data_in_valid && (codec_data_in != w_tbl_data);
        // a bad read-back rewrites the entry; a silent controller just re-reads it
        w_retry_st = codec_data_in_valid ? WR_ISSUE : RD_ISSUE;
      end
      default: ;
    endcase
    // a response arriving on the last allowed cycle beats the timeout
    w_fail = w_in_wait && (w_mismatch || (!w_resp && w_tmo_hit));
  end

  // Sequencer FSM with all status and controller-facing outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= PROBE_ISSUE;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_alive     <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_index     <= '0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        PROBE_ISSUE: if (!controller_busy) begin
          r_rd_en     <= 1'b1;
          r_addr      <= PROBE_ADDR;
          r_data      <= '0;
          r_tmo       <= '0;
          r_seen_busy <= 1'b0;
          r_state     <= PROBE_WAIT;
        end
        WR_ISSUE: if (!controller_busy) begin
          r_wr_en     <= 1'b1;
          r_addr      <= w_tbl_addr;
          r_data      <= w_tbl_data;
          r_tmo       <= '0;
          r_seen_busy <= 1'b0;
          r_state     <= WR_WAIT;
        end
        RD_ISSUE: if (!controller_busy) begin
          r_rd_en     <= 1'b1;
          r_addr      <= w_tbl_addr;
          r_data      <= w_tbl_data;
          r_tmo       <= '0;
          r_seen_busy <= 1'b0;
          r_state     <= RD_WAIT;
        end
        PROBE_WAIT, WR_WAIT, RD_WAIT: begin
          if (w_fail) begin
            if (w_can_retry) begin
              r_retry <= r_retry + RTY_W'(1);
              r_state <= w_retry_st;
            end else begin
              r_error <= 1'b1;
              r_addr  <= '0;
              r_data  <= '0;
              r_state <= ERROR;
            end
          end else if (w_resp) begin
            if (r_state == PROBE_WAIT) begin
              // the retry budget is per transaction, so the probe's retries are not carried into the writes
              r_alive <= 1'b1;
              r_index <= '0;
              r_retry <= '0;
              r_state <= WR_ISSUE;
            end else if (r_state == WR_WAIT) begin
              r_state <= VERIFY ? RD_ISSUE : NEXT;
            end else begin
              r_state <= NEXT;
            end
          end else begin
            r_tmo       <= r_tmo + TMO_W'(1);
            r_seen_busy <= r_seen_busy | controller_busy;
          end
        end
        NEXT: begin
          r_retry <= '0;
          if (w_last) begin
            r_done  <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_state <= DONE;
          end else begin
            r_index <= r_index + 8'd1;
            r_state <= WR_ISSUE;
          end
        end
        DONE, ERROR: if (restart) begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_alive <= 1'b0;
          r_index <= '0;
          r_retry <= '0;
          r_state <= PROBE_ISSUE;
        end
        default: r_state <= PROBE_ISSUE;
      endcase
    end
  end

  assign codec_rd_en    = r_rd_en;
  assign codec_wr_en    = r_wr_en;
  assign codec_reg_addr = r_addr;
  assign codec_data_out = r_data;
  assign codec_is_alive = r_alive;
  assign init_done      = r_done;
  assign init_error     = r_error;
  assign cur_index      = r_index;

endmodule

// File: tb/tb_codec_init_seq.sv
// tb/tb_codec_init_seq.sv - directed self-checking bench for codec_init_seq
module tb_codec_init_seq;

  logic       clk = 1'b0;
  logic       rst_nv, rst_v, restart, busy, valid, sel;
  logic [7:0] din;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         t_cyc, c1, c2, c3;
  bit         seen;

  logic       nv_rd_en, nv_wr_en, nv_alive, nv_done, nv_error;
  logic [3:0] nv_addr;
  logic [7:0] nv_data, nv_index;
  logic       v_rd_en, v_wr_en, v_alive, v_done, v_error;
  logic [3:0] v_addr;
  logic [7:0] v_data, v_index;

  logic       m_rd_en, m_wr_en;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign m_rd_en = sel ? nv_rd_en : v_rd_en;
  assign m_wr_en = sel ? nv_wr_en : v_wr_en;
  assign m_addr  = sel ? nv_addr  : v_addr;
  assign m_data  = sel ? nv_data  : v_data;

  codec_init_seq #(
    .ADDR_W(4), .DATA_W(8), .NUM_REGS(2), .INIT_TABLE(24'h500412),
    .PROBE_ADDR(4'h0), .VERIFY(1'b0), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_nv (
    .clk(clk), .reset_n(rst_nv), .restart(restart),
    .codec_rd_en(nv_rd_en), .codec_wr_en(nv_wr_en),
    .codec_reg_addr(nv_addr), .codec_data_out(nv_data),
    .codec_data_in(din), .codec_data_in_valid(valid), .controller_busy(busy),
    .codec_is_alive(nv_alive), .init_done(nv_done), .init_error(nv_error),
    .cur_index(nv_index)
  );

  codec_init_seq #(
    .ADDR_W(4), .DATA_W(8), .NUM_REGS(2), .INIT_TABLE(24'h500412),
    .PROBE_ADDR(4'h0), .VERIFY(1'b1), .TIMEOUT_CYCLES(16), .MAX_RETRIES(2)
  ) u_v (
    .clk(clk), .reset_n(rst_v), .restart(restart),
    .codec_rd_en(v_rd_en), .codec_wr_en(v_wr_en),
    .codec_reg_addr(v_addr), .codec_data_out(v_data),
    .codec_data_in(din), .codec_data_in_valid(valid), .controller_busy(busy),
    .codec_is_alive(v_alive), .init_done(v_done), .init_error(v_error),
    .cur_index(v_index)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input string tag, input bit exp_rd, input logic [3:0] exp_addr,
                            input logic [7:0] exp_data);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (m_rd_en || m_wr_en) found = 1'b1;
    end
    t_cyc = cyc;
    check({tag, "_seen"}, 32'(found), 32'd1);
    check({tag, "_kind"}, 32'(m_rd_en), 32'(exp_rd));
    check({tag, "_addr"}, 32'(m_addr), 32'(exp_addr));
    if (!exp_rd) check({tag, "_data"}, 32'(m_data), 32'(exp_data));
  endtask

  task automatic serve(input bit rd, input logic [7:0] rdata, input bit pulse_restart);
    busy = 1'b1;
    if (pulse_restart) restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("en_width", 32'(m_rd_en | m_wr_en), 32'd0);
    @(negedge clk);
    @(negedge clk);
    busy = 1'b0;
    if (rd) begin
      @(negedge clk);
      valid = 1'b1;
      din   = rdata;
      @(negedge clk);
      valid = 1'b0;
      din   = 8'h00;
    end
  endtask

  initial begin
    sel = 1'b1; rst_nv = 1'b0; rst_v = 1'b0; restart = 1'b0;
    busy = 1'b0; valid = 1'b0; din = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(v_rd_en), 32'd0);
    check("rst_wr_en", 32'(v_wr_en), 32'd0);
    check("rst_addr", 32'(v_addr), 32'd0);
    check("rst_data", 32'(v_data), 32'd0);
    check("rst_alive", 32'(v_alive), 32'd0);
    check("rst_done", 32'(v_done), 32'd0);
    check("rst_error", 32'(v_error), 32'd0);
    check("rst_index", 32'(v_index), 32'd0);

    // no-verify: probe then two plain writes
    rst_nv = 1'b1;
    expect_txn("nv_probe", 1'b1, 4'h0, 8'h00); serve(1'b1, 8'hA5, 1'b0);
    expect_txn("nv_wr0", 1'b0, 4'h4, 8'h12);   serve(1'b0, 8'h00, 1'b0);
    expect_txn("nv_wr1", 1'b0, 4'h5, 8'h00);   serve(1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("nv_done", 32'(nv_done), 32'd1);
    check("nv_alive", 32'(nv_alive), 32'd1);
    check("nv_error", 32'(nv_error), 32'd0);
    check("nv_index", 32'(nv_index), 32'd1);
    rst_nv = 1'b0;
    sel = 1'b0;

    // busy held for 10 cycles after reset release
    busy = 1'b1; rst_v = 1'b1; seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (v_rd_en || v_wr_en) seen = 1'b1;
    end
    check("gate_quiet", 32'(seen), 32'd0);
    busy = 1'b0;
    @(negedge clk);
    check("gate_first_rd", 32'(v_rd_en), 32'd1);
    check("gate_probe_addr", 32'(v_addr), 32'd0);
    serve(1'b1, 8'h5A, 1'b0);

    // verify: first read-back of entry 0 is wrong, restart pulse during a write is ignored
    expect_txn("v_wr0", 1'b0, 4'h4, 8'h12);    serve(1'b0, 8'h00, 1'b0);
    expect_txn("v_rd0", 1'b1, 4'h4, 8'h00);    serve(1'b1, 8'h13, 1'b0);
    expect_txn("v_wr0_again", 1'b0, 4'h4, 8'h12); serve(1'b0, 8'h00, 1'b0);
    expect_txn("v_rd0_again", 1'b1, 4'h4, 8'h00); serve(1'b1, 8'h12, 1'b0);
    expect_txn("v_wr1", 1'b0, 4'h5, 8'h00);    serve(1'b0, 8'h00, 1'b1);
    expect_txn("v_rd1", 1'b1, 4'h5, 8'h00);    serve(1'b1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("v_done", 32'(v_done), 32'd1);
    check("v_error", 32'(v_error), 32'd0);
    check("v_alive", 32'(v_alive), 32'd1);
    check("v_index", 32'(v_index), 32'd1);
    check("v_done_addr", 32'(v_addr), 32'd0);

    // restart from DONE
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("rs_done_clr", 32'(v_done), 32'd0);
    check("rs_alive_clr", 32'(v_alive), 32'd0);
    check("rs_index_clr", 32'(v_index), 32'd0);
    expect_txn("rs_probe", 1'b1, 4'h0, 8'h00); serve(1'b1, 8'h77, 1'b0);
    expect_txn("rs_wr0", 1'b0, 4'h4, 8'h12);

    // asynchronous reset while the write is outstanding
    rst_v = 1'b0;
    #1;
    check("ar_wr_en", 32'(v_wr_en), 32'd0);
    check("ar_addr", 32'(v_addr), 32'd0);
    check("ar_data", 32'(v_data), 32'd0);
    check("ar_alive", 32'(v_alive), 32'd0);
    @(negedge clk);
    rst_v = 1'b1;

    // probe never answered: three reads 17 cycles apart, then ERROR
    expect_txn("to_probe1", 1'b1, 4'h0, 8'h00); c1 = t_cyc;
    expect_txn("to_probe2", 1'b1, 4'h0, 8'h00); c2 = t_cyc;
    expect_txn("to_probe3", 1'b1, 4'h0, 8'h00); c3 = t_cyc;
    check("to_gap12", 32'(c2 - c1), 32'd17);
    check("to_gap23", 32'(c3 - c2), 32'd17);
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (v_rd_en || v_wr_en) seen = 1'b1;
    end
    check("to_no_4th", 32'(seen), 32'd0);
    check("to_error", 32'(v_error), 32'd1);
    check("to_alive", 32'(v_alive), 32'd0);
    check("to_index", 32'(v_index), 32'd0);
    check("to_done", 32'(v_done), 32'd0);

    // restart from ERROR
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("er_error_clr", 32'(v_error), 32'd0);
    expect_txn("er_probe", 1'b1, 4'h0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
